// File: rtl/arp_tx_if.sv
// rtl/arp_tx_if.sv - start/capture inputs and GMII frame outputs of the ARP frame generator
interface arp_tx_if;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        arp_tx_busy;
  logic        arp_tx_done;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;

  modport master (
    output arp_tx_en, arp_tx_type, des_mac, des_ip,
    input  arp_tx_busy, arp_tx_done, gmii_tx_en, gmii_txd
  );

  modport slave (
    input  arp_tx_en, arp_tx_type, des_mac, des_ip,
    output arp_tx_busy, arp_tx_done, gmii_tx_en, gmii_txd
  );
endinterface

// File: rtl/arp_tx.sv
// rtl/arp_tx.sv - ARP request/reply Ethernet II frame generator on 8-bit GMII with internal FCS
// Optional ARP_TX_BCAST_REQ_EN: requests go to broadcast dest MAC with zero target MAC.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input logic   clk,
  input logic   rst_n,
  arp_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH_HEAD, S_ARP_BODY, S_PAD, S_FCS, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [47:0]  dst_mac, tgt_mac;
  logic [7:0]   opcode;
  logic [7:0]   shift;
  logic [111:0] hdr, hdr_sh;
  logic [223:0] body, body_sh;
  logic [31:0]  fcs_sh;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
`ifdef ARP_TX_BCAST_REQ_EN
    dst_mac = type_q ? mac_q : 48'hFFFF_FFFF_FFFF;
    tgt_mac = type_q ? mac_q : 48'h0;
`else
    dst_mac = mac_q;
    tgt_mac = mac_q;
`endif
    opcode = type_q ? 8'h02 : 8'h01;
    hdr    = {dst_mac, BOARD_MAC, 16'h0806};
    body   = {16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, opcode,
              BOARD_MAC, BOARD_IP, tgt_mac, ip_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    type_d  = type_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        if (bus.arp_tx_en) begin
          state_d = S_PREAMBLE;
          type_d  = bus.arp_tx_type;
          mac_d   = bus.des_mac;
          ip_d    = bus.des_ip;
        end
      end
      S_PREAMBLE: if (cnt_q == 5'd7)  begin state_d = S_ETH_HEAD; cnt_d = 5'd0; end
      S_ETH_HEAD: if (cnt_q == 5'd13) begin state_d = S_ARP_BODY; cnt_d = 5'd0; end
      S_ARP_BODY: if (cnt_q == 5'd27) begin state_d = S_PAD;      cnt_d = 5'd0; end
      S_PAD:      if (cnt_q == 5'd17) begin state_d = S_FCS;      cnt_d = 5'd0; end
      S_FCS:      if (cnt_q == 5'd3)  begin state_d = S_DONE;     cnt_d = 5'd0; end
      S_DONE:     begin state_d = S_IDLE; cnt_d = 5'd0; end
      default:    begin state_d = S_IDLE; cnt_d = 5'd0; end
    endcase

    // Output registers carry the byte belonging to the next state/count.
    shift   = {cnt_d, 3'b000};
    hdr_sh  = hdr << shift;
    body_sh = body << shift;
    fcs_sh  = ~(crc_q >> shift);
    crc_d   = crc_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    case (state_d)
      S_IDLE: crc_d = 32'hFFFF_FFFF;
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = (cnt_d == 5'd7) ? 8'hD5 : 8'h55;
      end
      S_ETH_HEAD: begin
        tx_en_d = 1'b1;
        txd_d   = hdr_sh[111:104];
        crc_d   = crc_byte(crc_q, txd_d);
      end
      S_ARP_BODY: begin
        tx_en_d = 1'b1;
        txd_d   = body_sh[223:216];
        crc_d   = crc_byte(crc_q, txd_d);
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
      end
      S_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_sh[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      type_q  <= 1'b0;
      mac_q   <= 48'h0;
      ip_q    <= 32'h0;
      crc_q   <= 32'hFFFF_FFFF;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      crc_q   <= crc_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.arp_tx_busy = busy_q;
  assign bus.arp_tx_done = done_q;
  assign bus.gmii_tx_en  = tx_en_q;
  assign bus.gmii_txd    = txd_q;

endmodule

// File: tb/tb_arp_tx.sv
// tb/tb_arp_tx.sv - scoreboard bench for arp_tx against a byte-level frame model
module tb_arp_tx;
  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  arp_tx_if bus();

  arp_tx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #4 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int frames_exp = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] bld[$];
  logic rst_at_edge = 1'b0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected CRC-32 register (no final inversion) over d[lo..hi], one bit at a time.
  function automatic logic [31:0] crc_ref(input logic [7:0] d[$], input int lo, input int hi);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = lo; i <= hi; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic void put_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bld.push_back(v[8*i +: 8]);
  endfunction

  task automatic push_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    logic [47:0] dst;
    logic [47:0] tgt;
    logic [31:0] c;
    dst = mac;
    tgt = mac;
`ifdef ARP_TX_BCAST_REQ_EN
    if (!typ) begin
      dst = 48'hFFFF_FFFF_FFFF;
      tgt = 48'h0;
    end
`endif
    bld.delete();
    for (int i = 0; i < 7; i++) bld.push_back(8'h55);
    bld.push_back(8'hD5);
    put_bytes({16'h0, dst}, 6);
    put_bytes({16'h0, BOARD_MAC}, 6);
    put_bytes(64'h0806, 2);
    put_bytes(64'h0001_0800_0604, 6);
    put_bytes(typ ? 64'h2 : 64'h1, 2);
    put_bytes({16'h0, BOARD_MAC}, 6);
    put_bytes({32'h0, BOARD_IP}, 4);
    put_bytes({16'h0, tgt}, 6);
    put_bytes({32'h0, ip}, 4);
    for (int i = 0; i < 18; i++) bld.push_back(8'h00);
    c = ~crc_ref(bld, 8, 67);
    put_bytes({32'h0, c[7:0], c[15:8], c[23:16], c[31:24]}, 4);
    foreach (bld[i]) exp_q.push_back(bld[i]);
    frames_exp++;
  endtask

  // Accepts at the next edge; returns at the negedge of burst cycle 0.
  task automatic start(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    push_frame(typ, mac, ip);
    bus.arp_tx_type = typ;
    bus.des_mac     = mac;
    bus.des_ip      = ip;
    bus.arp_tx_en   = 1'b1;
    @(posedge clk); #1;
    bus.arp_tx_en   = 1'b0;
    @(negedge clk);
    check("first_preamble_en", {31'h0, bus.gmii_tx_en}, 32'h1);
    check("first_preamble_busy", {31'h0, bus.arp_tx_busy}, 32'h1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.arp_tx_done) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) rst_at_edge <= rst_n;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_at_edge) begin
      check("rst_tx_en", {31'h0, bus.gmii_tx_en}, 32'h0);
      check("rst_busy", {31'h0, bus.arp_tx_busy}, 32'h0);
      check("rst_done", {31'h0, bus.arp_tx_done}, 32'h0);
      check("rst_txd", {24'h0, bus.gmii_txd}, 32'h0);
      exp_q.delete();
      rx_q.delete();
      prev_en = 1'b0;
    end else begin
      if (bus.gmii_tx_en) begin
        check("busy_in_frame", {31'h0, bus.arp_tx_busy}, 32'h1);
        check("done_in_frame", {31'h0, bus.arp_tx_done}, 32'h0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", bus.gmii_txd);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", rx_q.size()), {24'h0, bus.gmii_txd}, {24'h0, e});
        end
        rx_q.push_back(bus.gmii_txd);
      end else begin
        check("idle_txd", {24'h0, bus.gmii_txd}, 32'h0);
        if (prev_en) begin
          check("done_after_fcs", {31'h0, bus.arp_tx_done}, 32'h1);
          check("busy_in_done", {31'h0, bus.arp_tx_busy}, 32'h1);
          check("frame_len", rx_q.size(), 32'd72);
          if (rx_q.size() == 72)
            check("fcs_residue", bitrev(crc_ref(rx_q, 8, 71)), 32'hC704DD7B);
          if (bus.arp_tx_done) frames_done++;
          rx_q.delete();
        end else if (bus.arp_tx_done) begin
          vectors++;
          errors++;
          $display("FAIL stray_done: got done=1 expected done=0 at %0t", $time);
        end
      end
      prev_en = bus.gmii_tx_en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [47:0] m;
    logic [31:0] ip;
    logic t;
    int k;
    bus.arp_tx_en   = 1'b0;
    bus.arp_tx_type = 1'b0;
    bus.des_mac     = 48'h0;
    bus.des_ip      = 32'h0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reply; des_ip change at burst 5, ignored pulses at burst 10 and in DONE,
    // then a request accepted the cycle after DONE.
    start(1'b1, 48'hA0B1C2D3E4F5, {8'd192, 8'd168, 8'd1, 8'd102});
    repeat (5) @(posedge clk);
    #1 bus.des_ip = 32'h0102_0304;
    repeat (5) @(posedge clk);
    #1;
    bus.arp_tx_en = 1'b1;
    bus.des_mac   = 48'h1234_5678_9ABC;
    bus.arp_tx_type = 1'b0;
    @(posedge clk); #1;
    bus.arp_tx_en = 1'b0;
    repeat (61) @(posedge clk);
    #1;
    bus.arp_tx_en = 1'b1;
    bus.des_mac   = 48'hDEAD_BEEF_0000;
    @(posedge clk); #1;
    start(1'b0, 48'hA0B1C2D3E4F5, {8'd192, 8'd168, 8'd1, 8'd102});
    wait_done();

    // Reset at burst cycle 30 aborts the frame without a done pulse.
    start(1'b1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0107);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    frames_exp--;
    repeat (3) @(posedge clk);
    #1;
    start(1'b1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0107);
    wait_done();

    for (int n = 0; n < 20; n++) begin
      r  = {$urandom(), $urandom()};
      m  = r[47:0];
      ip = $urandom();
      t  = r[63];
      start(t, m, ip);
      k = $urandom_range(1, 60);
      repeat (k) @(posedge clk);
      #1;
      r = {$urandom(), $urandom()};
      bus.des_mac = r[47:0];
      bus.des_ip  = r[63:32];
      bus.arp_tx_type = ~t;
      wait_done();
      k = $urandom_range(0, 5);
      repeat (k) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("leftover_bytes", exp_q.size(), 32'd0);
    check("frame_count", frames_done, frames_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
